// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared fetch-stage types and constants; IF_FETCH_MISALIGN_TRAP_EN adds the FAULT state
package if_pkg;

    typedef enum logic [2:0] {
        ST_REQ   = 3'd0,
        ST_WAIT  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_KILL  = 3'd3
`ifdef IF_FETCH_MISALIGN_TRAP_EN
        ,
        ST_FAULT = 3'd4
`endif
    } fetch_state_e;

    localparam logic [31:0] IF_RESET_PC  = 32'h0000_0000;
    // ADDI x0,x0,0 - also used by decode to insert bubbles
    localparam logic [31:0] IF_NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - single-outstanding instruction fetch stage; IF_FETCH_MISALIGN_TRAP_EN enables misaligned-redirect fault
module if_fetch
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = IF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = IF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        id_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        fetch_fault
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  instr_q;
    logic [31:0]  if_pc_q;
    logic         valid_q;
    logic [31:0]  redir_pc;
    logic         redirect_live;

`ifdef IF_FETCH_MISALIGN_TRAP_EN
    logic fault_q;
    logic redir_fault;

    assign redir_pc      = redirect_pc;
    assign redir_fault   = |redirect_pc[1:0];
    // once faulted, only reset leaves FAULT
    assign redirect_live = redirect_en && (state_q != ST_FAULT);
    assign fetch_fault   = fault_q;
`else
    logic unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign redir_pc            = {redirect_pc[31:2], 2'b00};
    assign redirect_live       = redirect_en;
    assign fetch_fault         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_PC;
            if_pc_q <= RESET_PC;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
`ifdef IF_FETCH_MISALIGN_TRAP_EN
            fault_q <= 1'b0;
`endif
        end else if (redirect_live) begin
            pc_q    <= redir_pc;
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            // a request already accepted must have its response drained in KILL
            case (state_q)
                ST_REQ:  state_q <= imem_gnt    ? ST_KILL : ST_REQ;
                ST_WAIT: state_q <= imem_rvalid ? ST_REQ  : ST_KILL;
                ST_KILL: state_q <= imem_rvalid ? ST_REQ  : ST_KILL;
                default: state_q <= ST_REQ;
            endcase
`ifdef IF_FETCH_MISALIGN_TRAP_EN
            if (redir_fault) begin
                state_q <= ST_FAULT;
                fault_q <= 1'b1;
            end
`endif
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (imem_gnt) state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        instr_q <= imem_rdata;
                        if_pc_q <= pc_q;
                        valid_q <= 1'b1;
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (id_ready) begin
                        pc_q    <= pc_q + 32'd4;
                        valid_q <= 1'b0;
                        instr_q <= NOP_INSTR;
                        state_q <= ST_REQ;
                    end
                end
                ST_KILL: begin
                    if (imem_rvalid) state_q <= ST_REQ;
                end
                default: ;
            endcase
        end
    end

    assign imem_req    = (state_q == ST_REQ) && !rst;
    assign imem_addr   = pc_q;
    assign if_valid    = valid_q;
    assign if_instr    = instr_q;
    assign if_pc       = if_pc_q;
    assign if_pc_plus4 = if_pc_q + 32'd4;

endmodule
